// File: rtl/mc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_pkg: shared state encodings and constants for the core control.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mc_pkg;
  localparam logic [2:0]  ST_IF   = 3'd0;
  localparam logic [2:0]  ST_ID   = 3'd1;
  localparam logic [2:0]  ST_EXE  = 3'd2;
  localparam logic [2:0]  ST_MEM  = 3'd3;
  localparam logic [2:0]  ST_WB   = 3'd4;
  localparam logic [2:0]  ST_HANG = 3'd5;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam logic [31:0] INST_BYTES   = 32'd4;
endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_wait_timer: counts unanswered SRAM request cycles.             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mc_wait_timer #(
  parameter int            TO_W    = 8,
  parameter logic [TO_W-1:0] TIMEOUT = 8'd200
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};

  // Flags the cycle whose increment reaches TIMEOUT, so the FSM leaves on that edge.
  assign expired_o = inc_i & (cnt_inc >= {1'b0, TIMEOUT});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_inc[TO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_ctrl_fsm: IF/ID/EXE/MEM/WB sequencer owning PC, IR and strobes.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter logic [31:0]     RESET_PC = RESET_PC_DEF,
  parameter int              TO_W     = 8,
  parameter logic [TO_W-1:0] TIMEOUT  = 8'd200
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  input  logic        inst_ready,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  input  logic        dec_nowb_br,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_gr_we,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        data_req,
  output logic        data_wr,
  input  logic        data_ready,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic [2:0]  state,
  output logic        hang
);
  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        hang_q, hang_d;
  logic        retire_c;
  logic [31:0] next_pc;
  logic        in_if, in_mem;
  logic        wd_inc, wd_expired;

  assign in_if   = (state_q == ST_IF);
  assign in_mem  = (state_q == ST_MEM);
  assign next_pc = br_taken ? br_target : (pc_q + INST_BYTES);

  // Any cycle that is not an unanswered request resets the watchdog.
  assign wd_inc = ~reset & ((in_if & ~inst_ready) | (in_mem & ~data_ready));

  mc_wait_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (wd_inc),
    .clr_i     (~wd_inc),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    hang_d   = hang_q;
    retire_c = 1'b0;
    case (state_q)
      ST_IF: begin
        if (wd_expired) begin
          state_d = ST_HANG;
          hang_d  = 1'b1;
        end else if (inst_ready) begin
          ir_d    = inst_rdata;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (dec_nowb_br) begin
          retire_c = 1'b1;
          pc_d     = next_pc;
          state_d  = ST_IF;
        end else begin
          state_d  = ST_EXE;
        end
      end
      ST_EXE: state_d = (dec_load | dec_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (wd_expired) begin
          state_d = ST_HANG;
          hang_d  = 1'b1;
        end else if (data_ready) begin
          if (dec_store) begin
            retire_c = 1'b1;
            pc_d     = next_pc;
            state_d  = ST_IF;
          end else begin
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        retire_c = 1'b1;
        pc_d     = next_pc;
        state_d  = ST_IF;
      end
      ST_HANG: state_d = ST_HANG;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IF;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      hang_q  <= hang_d;
    end
  end

  assign inst_req  = ~reset & in_if;
  assign data_req  = ~reset & in_mem;
  assign data_wr   = ~reset & in_mem & dec_store;
  assign rf_we     = ~reset & (state_q == ST_WB) & dec_gr_we;
  assign retire    = ~reset & retire_c;
  assign retire_pc = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign hang      = hang_q;
endmodule
`default_nettype wire
